audio_frame_buffer: RTL

//  Consumes the codec stage's line-in sample stream (line_in_l/r + new_sample strobe) and mixes it to mono.

---
 rtl/audio_frame_buffer_if.sv | 45 ++++
 rtl/audio_frame_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_frame_buffer_if
// Purpose  : Sample-in / frame-stream-out bundle for audio_frame_buffer.
//            The frame_peak/peak_valid fields exist only with PEAK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_frame_buffer_if #(
    parameter int FRAME_LEN = 256,
    parameter int DATA_W    = 16
);
    logic                         new_sample;
    logic [DATA_W-1:0]            line_in_l;
    logic [DATA_W-1:0]            line_in_r;
    logic [DATA_W-1:0]            out_data;
    logic [$clog2(FRAME_LEN)-1:0] out_index;
    logic                         out_last;
    logic                         out_valid;
    logic                         out_ready;
    logic                         overrun;
    logic [15:0]                  drop_count;
`ifdef PEAK_DETECT_EN
    logic [DATA_W-1:0]            frame_peak;
    logic                         peak_valid;
`endif

    // Environment side: drives samples and the sink's ready.
    modport master (
        output new_sample, line_in_l, line_in_r, out_ready,
        input  out_data, out_index, out_last, out_valid, overrun, drop_count
`ifdef PEAK_DETECT_EN
        , input frame_peak, peak_valid
`endif
    );

    // Buffer side.
    modport slave (
        input  new_sample, line_in_l, line_in_r, out_ready,
        output out_data, out_index, out_last, out_valid, overrun, drop_count
`ifdef PEAK_DETECT_EN
        , output frame_peak, peak_valid
`endif
    );
endinterface
`default_nettype wire

// File: rtl/audio_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : audio_frame_buffer
// Purpose  : Stereo-to-mono mixer feeding a ping-pong frame RAM, streamed out
//            over valid/ready. Optional per-frame peak detector: PEAK_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_frame_buffer #(
    parameter int FRAME_LEN = 256,
    parameter int DATA_W    = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    audio_frame_buffer_if.slave  bus
);
    localparam int               c_IDX_W    = $clog2(FRAME_LEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    rd_state_t            r_state;
    rd_state_t            w_state_nxt;

    logic [DATA_W-1:0]    r_mem [2*FRAME_LEN];
    logic [DATA_W-1:0]    r_rd_data;

    logic [1:0]           r_full;
    logic [1:0]           w_full_nxt;
    logic                 r_wr_bank;
    logic [c_IDX_W-1:0]   r_wr_ptr;
    logic                 r_rd_bank;
    logic [c_IDX_W-1:0]   r_rd_ptr;

    logic [DATA_W-1:0]    r_out_data;
    logic [c_IDX_W-1:0]   r_out_index;
    logic                 r_out_last;
    logic                 r_out_valid;
    logic                 r_overrun;
    logic [15:0]          r_drop_count;

    logic [DATA_W-1:0]    w_l_half;
    logic [DATA_W-1:0]    w_r_half;
    logic [DATA_W-1:0]    w_mono;
    logic                 w_xfer;
    logic                 w_rd_en;
    logic                 w_load;
    logic                 w_advance;
    logic                 w_release;
    logic                 w_bank_free;
    logic                 w_wr_en;
    logic                 w_wr_done;
    logic                 w_drop;

    // floor((l+r)/2) == (l>>>1)+(r>>>1)+(l0&r0); stays within DATA_W bits.
    assign w_l_half = {bus.line_in_l[DATA_W-1], bus.line_in_l[DATA_W-1:1]};
    assign w_r_half = {bus.line_in_r[DATA_W-1], bus.line_in_r[DATA_W-1:1]};
    assign w_mono   = w_l_half + w_r_half
                    + {{(DATA_W-1){1'b0}}, bus.line_in_l[0] & bus.line_in_r[0]};

    assign w_xfer = r_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = RD_LOAD;
                end
            end
            RD_LOAD: begin
                // Present beat 0 and prefetch beat 1 so a ready sink never waits.
                w_load      = 1'b1;
                w_rd_en     = 1'b1;
                w_state_nxt = RD_STREAM;
            end
            RD_STREAM: begin
                if (w_xfer) begin
                    if (r_out_last) begin
                        w_release   = 1'b1;
                        w_state_nxt = RD_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        w_rd_en   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    // A release in the same cycle frees the bank for the incoming sample.
    assign w_bank_free = !r_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank));
    assign w_wr_en     = bus.new_sample && w_bank_free && !rst;
    assign w_wr_done   = w_wr_en && (r_wr_ptr == c_LAST_IDX);
    assign w_drop      = bus.new_sample && !w_bank_free;

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_ptr}] <= w_mono;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[{r_rd_bank, r_rd_ptr}];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full       <= 2'b00;
            r_wr_bank    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_bank    <= 1'b0;
            r_rd_ptr     <= '0;
            r_overrun    <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_IDX_W'(1);
                if (w_wr_done) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
                r_rd_ptr  <= '0;
            end else if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_rd_data;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b1;
        end else if (w_advance) begin
            r_out_data  <= r_rd_data;
            r_out_index <= r_out_index + c_IDX_W'(1);
            r_out_last  <= (r_out_index == (c_LAST_IDX - c_IDX_W'(1)));
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_data   = r_out_data;
    assign bus.out_index  = r_out_index;
    assign bus.out_last   = r_out_last;
    assign bus.out_valid  = r_out_valid;
    assign bus.overrun    = r_overrun;
    assign bus.drop_count = r_drop_count;

`ifdef PEAK_DETECT_EN
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] w_pk_max;
    logic [DATA_W-1:0] r_pk;
    logic [DATA_W-1:0] r_frame_peak;
    logic              r_peak_valid;

    // Unsigned magnitude: the most negative sample maps to 2^(DATA_W-1).
    assign w_abs    = w_mono[DATA_W-1] ? (~w_mono + DATA_W'(1)) : w_mono;
    assign w_pk_max = (w_abs > r_pk) ? w_abs : r_pk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pk         <= '0;
            r_frame_peak <= '0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_wr_en) begin
                if (w_wr_done) begin
                    r_frame_peak <= w_pk_max;
                    r_peak_valid <= 1'b1;
                    r_pk         <= '0;
                end else begin
                    r_pk <= w_pk_max;
                end
            end
        end
    end

    assign bus.frame_peak = r_frame_peak;
    assign bus.peak_valid = r_peak_valid;
`endif

endmodule
`default_nettype wire
